vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock `vga_clk`.
- Drives the pixel coordinates and active-video flag consumed by the sprite/palette renderers, plus `hs`/`vs` to the VGA connector.
- It is the producer side of the DrawX/DrawY/blank interface. Renderers read ROM on the falling edge and register colour on the next rising edge.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- Derived: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). All parameter values must keep counts below 1024.

Ports:
- vga_clk  input  1  pixel clock, 25 MHz
- reset_n  input  1  asynchronous reset, active-low
- DrawX  output  10  current horizontal count hc (0..H_TOTAL-1)
- DrawY  output  10  current vertical count vc (0..V_TOTAL-1)
- blank  output  1  1 = active video (hc<H_VISIBLE and vc<V_VISIBLE), 0 = blanked
- hs  output  1  horizontal sync, active-low
- vs  output  1  vertical sync, active-low
- sync  output  1  composite sync for DAC, tied 0
- line_start  output  1  one-cycle pulse when hc==0
- frame_start  output  1  one-cycle pulse when hc==0 and vc==0

Behaviour:
- Clock and reset: one clock, `vga_clk`. Reset is asynchronous and active-low on `reset_n`. Every register clears asynchronously on `reset_n`=0.
- Reset values, chosen so the first edge after release enters pixel (0,0):
  - hc = H_TOTAL-1 (799), vc = V_TOTAL-1 (524)
  - DrawX = 799, DrawY = 524
  - blank = 0, hs = 1, vs = 1
  - line_start = 0, frame_start = 0
- Horizontal counter: each rising edge, if hc == H_TOTAL-1 then hc <= 0, else hc <= hc+1.
- Vertical counter:
  - Advances only on the edge where hc wraps.
  - vc == V_TOTAL-1 at that edge -> vc <= 0; otherwise vc <= vc+1.
  - The simultaneous hc/vc wrap at (799,524) -> (0,0) occurs on a single edge.
- All outputs are registers, with no combinational paths from counters to ports.
  - Next-state values of hs, vs, blank, line_start and frame_start are computed from next hc/vc.
  - This keeps every output aligned to the same cycle as DrawX/DrawY (zero skew) and glitch-free.
- hs = 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. hc 656..751.
- vs = 0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC, i.e. vc 490..491, for all hc on those lines.
- blank = 1 iff hc < 640 and vc < 480.
- Pulses: line_start = 1 for exactly the cycle with hc==0. frame_start = 1 for exactly the cycle with hc==0, vc==0.
- Period: one frame is exactly 800 × 525 = 420000 clocks.
- Mid-operation reset: asserting `reset_n` mid-frame immediately forces the reset values. After release, counting restarts at (0,0) on the first edge, with no partial-line artefacts.
- Width rule: hc and vc are 10-bit. The wrap compare is an equality against H_TOTAL-1 / V_TOTAL-1, never a natural overflow.

Optional Feature:
- Macro: VGA_PIPE_DELAY_EN.
- When defined:
  - hs, vs and blank pass through one extra register stage, so they lag DrawX/DrawY by exactly 1 clock.
  - This matches renderers that register colour one cycle after sampling the coordinates.
  - The delay registers reset to hs=1, vs=1, blank=0.
  - line_start and frame_start are not delayed.
- When undefined: all outputs are aligned with DrawX/DrawY, as specified above.

Test Plan:
- Hold reset_n=0 for 5 clocks, then release -> during reset DrawX=799, DrawY=524, blank=0, hs=vs=1. On first edge DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1.
- Run 800 clocks from (0,0):
  - blank falls when DrawX becomes 640.
  - hs=0 exactly for DrawX 656..751 (96 clocks).
  - DrawY increments 0->1 when DrawX wraps 799->0.
  - line_start pulses once per 800 clocks.
- Run a full frame -> vs=0 exactly while DrawY is 490..491 (1600 clocks). blank is never 1 for DrawY ≥ 480. frame_start pulses at clock 0 and again at clock 420000.
- Boundary pixel: at DrawX=799, DrawY=524 -> next edge gives DrawX=0, DrawY=0, frame_start=1. No cycle shows DrawY=525 or DrawX=800.
- Assert reset_n=0 asynchronously mid-line at DrawX=300, DrawY=200 -> outputs change to reset values without waiting for an edge. After release, the sequence restarts at (0,0).
- With VGA_PIPE_DELAY_EN defined -> blank falls 1 clock after DrawX becomes 640. hs=0 while DrawX is 657..752. frame_start still coincides with DrawX=0, DrawY=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster timing generator: pixel coordinates, active-video flag and syncs.
// Optional VGA_PIPE_DELAY_EN adds one register stage on hs/vs/blank to match registered-colour renderers.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hc, vc;
  logic [9:0] hc_nxt, vc_nxt;
  logic       hs_nxt, vs_nxt, blank_nxt;
  logic       hs_a, vs_a, blank_a;

  // Outputs are derived from the next counter values so they register in step with DrawX/DrawY.
  always_comb begin
    hc_nxt = (hc == H_MAX) ? '0 : hc + 10'd1;
    vc_nxt = vc;
    if (hc == H_MAX) begin
      vc_nxt = (vc == V_MAX) ? '0 : vc + 10'd1;
    end
    hs_nxt    = !((hc_nxt >= H_SYNC_BEG) && (hc_nxt < H_SYNC_END));
    vs_nxt    = !((vc_nxt >= V_SYNC_BEG) && (vc_nxt < V_SYNC_END));
    blank_nxt = (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc          <= H_MAX;
      vc          <= V_MAX;
      hs_a        <= 1'b1;
      vs_a        <= 1'b1;
      blank_a     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      hs_a        <= hs_nxt;
      vs_a        <= vs_nxt;
      blank_a     <= blank_nxt;
      line_start  <= (hc_nxt == '0);
      frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
    end
  end

`ifdef VGA_PIPE_DELAY_EN
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs    <= 1'b1;
      vs    <= 1'b1;
      blank <= 1'b0;
    end else begin
      hs    <= hs_a;
      vs    <= vs_a;
      blank <= blank_a;
    end
  end
`else
  assign hs    = hs_a;
  assign vs    = vs_a;
  assign blank = blank_a;
`endif

  assign DrawX = hc;
  assign DrawY = vc;
  assign sync  = 1'b0;

endmodule
